// File: rtl/dmem_access_ctrl.sv
// Memory-stage data-RAM access controller: turns M-stage load/store controls into a
// req/gnt/rvalid transaction and returns extended load data plus a stall term.
module dmem_access_ctrl #(
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned TO_W    = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MemRead_M,
  input  logic        MemWrite_M,
  input  logic [2:0]  funct3_M,
  input  logic [31:0] ALUResult_M,
  input  logic [31:0] WriteData_M,
  input  logic        valid_M,
  input  logic        flush_M,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_be,
  input  logic        dmem_gnt,
  input  logic        dmem_rvalid,
  input  logic [31:0] dmem_rdata,
  output logic        mem_busy_M,
  output logic [31:0] ReadData_M,
  output logic        mem_err_M
);

  typedef enum logic [2:0] {StIdle, StReq, StWait, StDone, StDrain} state_e;

  state_e          state_q;
  logic [TO_W-1:0] cnt_q;
  logic [31:0]     rdata_q;
  logic            err_q;

  logic        access, is_load, is_half, is_word, misaligned, timeout;
  logic [7:0]  lane_b;
  logic [15:0] lane_h;
  logic [31:0] load_ext;

  // A load wins when both read and write are set.
  assign access     = (MemRead_M | MemWrite_M) & ~flush_M;
  assign is_load    = MemRead_M;
  assign is_half    = (funct3_M[1:0] == 2'b01);
  assign is_word    = (funct3_M[1:0] == 2'b10);
  assign misaligned = (is_half & ALUResult_M[0]) | (is_word & (ALUResult_M[1:0] != 2'b00));
  assign timeout    = (cnt_q >= TO_W'(TIMEOUT - 1));

  assign dmem_req   = (state_q == StReq);
  assign dmem_addr  = {ALUResult_M[31:2], 2'b00};
  assign mem_busy_M = ((state_q == StIdle) & access) | (state_q == StReq) |
                      (state_q == StWait) | ((state_q == StDrain) & access);
  assign ReadData_M = rdata_q;
  assign mem_err_M  = err_q;

  always_comb begin
    lane_b = dmem_rdata[{ALUResult_M[1:0], 3'b000} +: 8];
    lane_h = dmem_rdata[{ALUResult_M[1], 4'b0000} +: 16];
    case (funct3_M)
      3'b000:  load_ext = {{24{lane_b[7]}}, lane_b};
      3'b001:  load_ext = {{16{lane_h[15]}}, lane_h};
      3'b100:  load_ext = {24'b0, lane_b};
      3'b101:  load_ext = {16'b0, lane_h};
      default: load_ext = dmem_rdata;
    endcase
  end

  always_comb begin
    case (funct3_M[1:0])
      2'b00:   dmem_wdata = {4{WriteData_M[7:0]}};
      2'b01:   dmem_wdata = {2{WriteData_M[15:0]}};
      default: dmem_wdata = WriteData_M;
    endcase
    dmem_we = 1'b0;
    dmem_be = 4'b0000;
    if (dmem_req) begin
      dmem_we = ~is_load;
      if (is_load) begin
        dmem_be = 4'b1111;
      end else begin
        case (funct3_M[1:0])
          2'b00:   dmem_be = 4'b0001 << ALUResult_M[1:0];
          2'b01:   dmem_be = 4'b0011 << {ALUResult_M[1], 1'b0};
          default: dmem_be = 4'b1111;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (access) begin
            if (misaligned) begin
              state_q <= StDone;
              err_q   <= 1'b1;
              rdata_q <= '0;
            end else begin
              state_q <= StReq;
              cnt_q   <= '0;
            end
          end
        end
        StReq: begin
          cnt_q <= cnt_q + TO_W'(1);
          // A load granted in the flush cycle still owes us an rvalid.
          if (flush_M) begin
            state_q <= (dmem_gnt & is_load) ? StDrain : StIdle;
          end else if (dmem_gnt & ~is_load) begin
            state_q <= StDone;
            err_q   <= 1'b0;
            rdata_q <= '0;
          end else if (timeout) begin
            state_q <= StDone;
            err_q   <= 1'b1;
            rdata_q <= '0;
          end else if (dmem_gnt) begin
            state_q <= StWait;
          end
        end
        StWait: begin
          cnt_q <= cnt_q + TO_W'(1);
          if (flush_M) begin
            state_q <= dmem_rvalid ? StIdle : StDrain;
          end else if (dmem_rvalid) begin
            state_q <= StDone;
            err_q   <= 1'b0;
            rdata_q <= load_ext;
          end else if (timeout) begin
            state_q <= StDone;
            err_q   <= 1'b1;
            rdata_q <= '0;
          end
        end
        StDrain: begin
          if (dmem_rvalid) state_q <= StIdle;
        end
        StDone: begin
          if (valid_M | flush_M) begin
            state_q <= StIdle;
            err_q   <= 1'b0;
            rdata_q <= '0;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
